// File: rtl/icb_sram_slv.sv
// ICB responder in front of a word-addressed single-port SRAM.
// Commands are accepted one per cycle; responses return strictly in order
// through a one-entry pipeline stage (s1) and a small response FIFO.
module icb_sram_slv #(
    parameter int unsigned    AW         = 32,
    parameter int unsigned    DW         = 32,
    parameter int unsigned    DEPTH_LOG2 = 12,
    parameter logic [AW-1:0]  BASE_ADDR  = 32'h4000_0000,
    parameter int unsigned    RSP_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic [AW-1:0]     icb_cmd_addr,
    input  logic              icb_cmd_read,
    input  logic [DW-1:0]     icb_cmd_wdata,
    input  logic [DW/8-1:0]   icb_cmd_wmask,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic [DW-1:0]     icb_rsp_rdata,
    output logic              icb_rsp_err
);

    localparam int unsigned MW    = DW / 8;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW    = $clog2(RSP_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(RSP_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(RSP_DEPTH);

    logic [DW-1:0]         mem [DEPTH];
    logic [DW-1:0]         rd_q;

    logic                  cmd_hs;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  unused_addr_lsb;

    logic                  s1_valid;
    logic                  s1_read;
    logic                  s1_err;
    logic [DW-1:0]         s1_rdata;

    logic [DW-1:0]         fifo_rdata [RSP_DEPTH];
    logic                  fifo_err   [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_cnt;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [CW:0]           occupancy;

    assign in_range        = (icb_cmd_addr[AW-1:DEPTH_LOG2+2] == BASE_ADDR[AW-1:DEPTH_LOG2+2]);
    assign word_idx        = icb_cmd_addr[DEPTH_LOG2+1:2];
    assign unused_addr_lsb = ^icb_cmd_addr[1:0];

    // Ready depends on registered occupancy only, never on icb_rsp_ready.
    assign occupancy     = {1'b0, fifo_cnt} + {{CW{1'b0}}, s1_valid};
    assign icb_cmd_ready = (occupancy < DEPTH_OCC);
    assign cmd_hs        = icb_cmd_valid & icb_cmd_ready;

    assign s1_rdata   = (s1_valid & s1_read & ~s1_err) ? rd_q : '0;
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = ~fifo_empty & icb_rsp_ready;
    // s1 is bypassed only when the FIFO is empty and the response is taken.
    assign push       = s1_valid & ~(fifo_empty & icb_rsp_ready);

    // SRAM: byte-masked write and synchronous read, no reset on contents.
    always_ff @(posedge clk) begin
        if (cmd_hs && in_range) begin
            if (icb_cmd_read) begin
                rd_q <= mem[word_idx];
            end else begin
                for (int unsigned i = 0; i < MW; i++) begin
                    if (icb_cmd_wmask[i]) begin
                        mem[word_idx][i*8 +: 8] <= icb_cmd_wdata[i*8 +: 8];
                    end
                end
            end
        end
    end

    // s1 stage: one response slot loaded on every accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_read  <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= cmd_hs;
            if (cmd_hs) begin
                s1_read <= icb_cmd_read;
                s1_err  <= ~in_range;
            end
        end
    end

    // Response FIFO storage; validity is tracked by the counter.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rdata[wr_ptr] <= s1_rdata;
            fifo_err[wr_ptr]   <= s1_err;
        end
    end

    // Response FIFO pointers and count, wrapping modulo RSP_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Overflow and underflow are impossible by construction; flag them if seen.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push && !pop && fifo_cnt == FULL_CNT))
                else $error("response fifo push while full");
            assert (!(pop && fifo_empty))
                else $error("response fifo pop while empty");
        end
    end

    // Output mux: FIFO head when non-empty, otherwise s1 bypass.
    always_comb begin
        icb_rsp_valid = ~fifo_empty | s1_valid;
        icb_rsp_rdata = s1_rdata;
        icb_rsp_err   = s1_valid & s1_err;
        if (!fifo_empty) begin
            icb_rsp_rdata = fifo_rdata[rd_ptr];
            icb_rsp_err   = fifo_err[rd_ptr];
        end
    end

endmodule
